// File: rtl/ecg_pkg.sv
// Shared constants and state type for the ECG frame loading path.
package ecg_pkg;

    localparam int FRAME_BYTES = 184;
    localparam int FRAME_BITS  = FRAME_BYTES * 8;
    localparam int BLOCK_BITS  = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        HOLD  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/ecg_gap_timer.sv
// Counts idle cycles between bytes of a partial frame; expired_o flags the cycle
// on which the gap reaches TIMEOUT_CYCLES. Only built when FRAME_TIMEOUT_EN is defined.
module ecg_gap_timer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Asserted during the idle cycle whose closing edge completes the gap.
    assign expired_o = enable_i && !clear_i && (count_q == LAST_COUNT);

endmodule

// File: rtl/ecg_frame_loader.sv
// Assembles UART bytes into one ECG frame, requests encryption, and holds the frame
// until released. Optional inter-byte timeout is enabled by defining FRAME_TIMEOUT_EN.
module ecg_frame_loader #(
    parameter int FRAME_BYTES    = ecg_pkg::FRAME_BYTES,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic [7:0]               byte_i,
    input  logic                     byte_valid_i,
    output logic                     byte_ready_o,
    input  logic                     done_i,
    output logic [FRAME_BYTES*8-1:0] data_o,
    output logic                     start_o,
    output logic                     frame_ready_o,
    output logic [7:0]               byte_count_o,
    output logic                     error_o
);
    import ecg_pkg::*;

    localparam int DW = FRAME_BYTES * 8;
    localparam logic [7:0] LAST_BYTE = 8'(FRAME_BYTES - 1);

    loader_state_e  state_q;
    logic [DW-1:0]  data_q;
    logic [DW-1:0]  data_d;
    logic [7:0]     count_q;
    logic           ready_q;
    logic           start_q;
    logic           frame_ready_q;
    logic           error_q;
    logic           accept;
    logic           expired;

    assign accept = byte_valid_i && ready_q;
    assign data_d = {data_q[DW-9:0], byte_i};

`ifdef FRAME_TIMEOUT_EN
    ecg_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .clear_i  (accept || (state_q != LOAD)),
        .enable_i (state_q == LOAD),
        .expired_o(expired)
    );
`else
    assign expired = 1'b0;
`endif

    // Outputs are registered alongside the state so they change only on clock edges.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            data_q        <= '0;
            count_q       <= '0;
            ready_q       <= 1'b1;
            start_q       <= 1'b0;
            frame_ready_q <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            start_q <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        data_q  <= data_d;
                        count_q <= 8'd1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        data_q <= data_d;
                        if (count_q == LAST_BYTE) begin
                            count_q       <= '0;
                            state_q       <= START;
                            start_q       <= 1'b1;
                            frame_ready_q <= 1'b1;
                            ready_q       <= 1'b0;
                        end else begin
                            count_q <= count_q + 8'd1;
                        end
                    end else if (expired) begin
                        error_q <= 1'b1;
                        count_q <= '0;
                        state_q <= IDLE;
                    end
                end
                START: begin
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (done_i) begin
                        state_q       <= IDLE;
                        frame_ready_q <= 1'b0;
                        ready_q       <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign byte_ready_o  = ready_q;
    assign data_o        = data_q;
    assign start_o       = start_q;
    assign frame_ready_o = frame_ready_q;
    assign byte_count_o  = count_q;
    assign error_o       = error_q;

endmodule

// File: tb/tb_ecg_frame_loader.sv
// Randomised self-checking bench for ecg_frame_loader; the reference model keeps the
// accepted-byte history and derives the expected frame and count from it.
module tb_ecg_frame_loader;

    localparam int FB = 184;
    localparam int DW = FB * 8;
    localparam int TO = 16;

    logic          clock_i = 1'b0;
    logic          reset_i = 1'b0;
    logic [7:0]    byte_i = 8'h00;
    logic          byte_valid_i = 1'b0;
    logic          byte_ready_o;
    logic          done_i = 1'b0;
    logic [DW-1:0] data_o;
    logic          start_o;
    logic          frame_ready_o;
    logic [7:0]    byte_count_o;
    logic          error_o;

    int checks = 0;
    int errors = 0;
    int start_pulses = 0;
    int error_pulses = 0;
    int exp_count = 0;
    logic [7:0] hist[$];

    ecg_frame_loader #(
        .FRAME_BYTES   (FB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .done_i       (done_i),
        .data_o       (data_o),
        .start_o      (start_o),
        .frame_ready_o(frame_ready_o),
        .byte_count_o (byte_count_o),
        .error_o      (error_o)
    );

    always #5 clock_i = ~clock_i;

    always @(negedge clock_i) begin
        if (start_o) start_pulses++;
        if (error_o) error_pulses++;
    end

    // data_o must equal the most recent FB accepted bytes, oldest in the top byte.
    function automatic logic [DW-1:0] exp_data();
        logic [DW-1:0] e;
        int n;
        e = '0;
        n = hist.size();
        for (int i = 0; i < n; i++) e[(n-1-i)*8 +: 8] = hist[i];
        return e;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        byte_i = b;
        byte_valid_i = 1'b1;
        @(posedge clock_i);
        #1;
        byte_valid_i = 1'b0;
        hist.push_back(b);
        if (hist.size() > FB) void'(hist.pop_front());
        exp_count = (exp_count + 1) % FB;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock_i);
        #1;
    endtask

    task automatic do_reset();
        #2;
        reset_i = 1'b1;
        idle(2);
        reset_i = 1'b0;
        hist.delete();
        exp_count = 0;
    endtask

    task automatic send_random(input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            send_byte(8'($urandom_range(0, 255)));
            if (max_gap > 0 && i != n - 1) idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic check_frame_start(input string name);
        checks++;
        if (start_o !== 1'b1 || frame_ready_o !== 1'b1 || byte_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_start: start=%b frame_ready=%b ready=%b, required 1 1 0",
                     name, start_o, frame_ready_o, byte_ready_o);
        end
        checks++;
        if (data_o !== exp_data()) begin
            errors++;
            $display("FAIL %s_data: got %h required %h", name, data_o, exp_data());
        end
        $display("frame %s: start=%b top=%h low=%h", name, start_o, data_o[DW-1 -: 8], data_o[7:0]);
    endtask

    task automatic release_frame(input string name);
        idle(1);
        done_i = 1'b1;
        idle(1);
        done_i = 1'b0;
        checks++;
        if (frame_ready_o !== 1'b0 || byte_ready_o !== 1'b1 || data_o !== exp_data()) begin
            errors++;
            $display("FAIL %s_release: frame_ready=%b ready=%b data_match=%b, required 0 1 1",
                     name, frame_ready_o, byte_ready_o, data_o === exp_data());
        end
    endtask

    task automatic test_reset();
        #1 reset_i = 1'b1;
        #2;
        checks++;
        if (data_o !== '0 || byte_count_o !== 8'd0 || start_o !== 1'b0 ||
            frame_ready_o !== 1'b0 || error_o !== 1'b0 || byte_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset: data_zero=%b count=%0d start=%b frame_ready=%b error=%b ready=%b, required 1 0 0 0 0 1",
                     data_o === '0, byte_count_o, start_o, frame_ready_o, error_o, byte_ready_o);
        end
        idle(2);
        reset_i = 1'b0;
        hist.delete();
        exp_count = 0;
    endtask

    task automatic test_back_to_back();
        int s0;
        s0 = start_pulses;
        for (int i = 0; i < FB; i++) begin
            send_byte(8'(i));
            if (i < FB - 1) begin
                checks++;
                if (byte_count_o !== 8'(i + 1)) begin
                    errors++;
                    $display("FAIL b2b_count: got %0d required %0d", byte_count_o, i + 1);
                end
            end
        end
        check_frame_start("b2b");
        checks++;
        if (data_o[DW-1 -: 8] !== 8'h00 || data_o[7:0] !== 8'hB7 || byte_count_o !== 8'd0) begin
            errors++;
            $display("FAIL b2b_ends: top=%h low=%h count=%0d, required 00 b7 0",
                     data_o[DW-1 -: 8], data_o[7:0], byte_count_o);
        end
        idle(1);
        checks++;
        if (start_o !== 1'b0 || frame_ready_o !== 1'b1 || start_pulses - s0 != 1) begin
            errors++;
            $display("FAIL b2b_hold: start=%b frame_ready=%b pulses=%0d, required 0 1 1",
                     start_o, frame_ready_o, start_pulses - s0);
        end
        release_frame("b2b");
    endtask

    task automatic test_gaps();
        int s0;
        s0 = start_pulses;
        for (int i = 0; i < FB; i++) begin
            send_byte(8'(i));
            if (i != FB - 1) idle($urandom_range(0, 5));
        end
        check_frame_start("gaps");
        idle(3);
        checks++;
        if (start_pulses - s0 != 1) begin
            errors++;
            $display("FAIL gaps_pulses: got %0d required 1", start_pulses - s0);
        end
        release_frame("gaps");
    endtask

    task automatic test_hold();
        do_reset();
        send_random(FB, 0);
        check_frame_start("hold");
        idle(1);
        byte_i = 8'h5A;
        byte_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            checks++;
            if (byte_ready_o !== 1'b0 || data_o !== exp_data() || byte_count_o !== 8'd0) begin
                errors++;
                $display("FAIL hold_blocked: ready=%b data_match=%b count=%0d, required 0 1 0",
                         byte_ready_o, data_o === exp_data(), byte_count_o);
            end
        end
        done_i = 1'b1;
        idle(1);
        done_i = 1'b0;
        checks++;
        if (byte_ready_o !== 1'b1 || byte_count_o !== 8'd0 || frame_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: ready=%b count=%0d frame_ready=%b, required 1 0 0",
                     byte_ready_o, byte_count_o, frame_ready_o);
        end
        send_byte(8'h5A);
        checks++;
        if (byte_count_o !== 8'd1 || data_o !== exp_data()) begin
            errors++;
            $display("FAIL hold_next: count=%0d low=%h, required 1 5a", byte_count_o, data_o[7:0]);
        end
    endtask

    task automatic test_done_ignored();
        do_reset();
        send_random(40, 2);
        done_i = 1'b1;
        idle(1);
        done_i = 1'b0;
        checks++;
        if (byte_count_o !== 8'd40 || frame_ready_o !== 1'b0 || byte_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL done_ignored: count=%0d frame_ready=%b ready=%b, required 40 0 1",
                     byte_count_o, frame_ready_o, byte_ready_o);
        end
        send_byte(8'($urandom_range(0, 255)));
        checks++;
        if (byte_count_o !== 8'd41) begin
            errors++;
            $display("FAIL done_next_count: got %0d required 41", byte_count_o);
        end
        send_random(FB - 41, 0);
        check_frame_start("done_ignored");
        release_frame("done_ignored");
    endtask

    task automatic test_reset_mid();
        int s0;
        do_reset();
        s0 = start_pulses;
        send_random(100, 0);
        #2;
        reset_i = 1'b1;
        #1;
        checks++;
        if (data_o !== '0 || byte_count_o !== 8'd0 || byte_ready_o !== 1'b1 || start_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: data_zero=%b count=%0d ready=%b start=%b, required 1 0 1 0",
                     data_o === '0, byte_count_o, byte_ready_o, start_o);
        end
        idle(2);
        reset_i = 1'b0;
        hist.delete();
        exp_count = 0;
        checks++;
        if (start_pulses != s0) begin
            errors++;
            $display("FAIL reset_mid_start: got %0d pulses required 0", start_pulses - s0);
        end
        send_random(FB, 3);
        check_frame_start("after_reset");
        release_frame("after_reset");
    endtask

    task automatic test_timeout();
        int e0;
        do_reset();
        send_random(50, 0);
        e0 = error_pulses;
        idle(TO + 4);
`ifdef FRAME_TIMEOUT_EN
        exp_count = 0;
        checks++;
        if (error_pulses - e0 != 1 || byte_count_o !== 8'd0) begin
            errors++;
            $display("FAIL timeout: pulses=%0d count=%0d, required 1 0", error_pulses - e0, byte_count_o);
        end
`else
        checks++;
        if (error_pulses - e0 != 0 || byte_count_o !== 8'd50) begin
            errors++;
            $display("FAIL no_timeout: pulses=%0d count=%0d, required 0 50", error_pulses - e0, byte_count_o);
        end
`endif
        send_random(FB - exp_count, 2);
        check_frame_start("timeout");
        release_frame("timeout");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_hold();
        test_done_ignored();
        test_reset_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ecg_frame_loader.md
ECG_FRAME_LOADER -- requirements
Module: ecg_frame_loader

Interface
REQ-001 Parameter FRAME_BYTES, default 184, bytes per ECG frame (23 blocks x 8 bytes).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000, maximum idle clock cycles between bytes of a partial frame.
REQ-003 clock_i  in  1  system clock; all logic on rising edge.
REQ-004 reset_i  in  1  reset, asynchronous, active-high.
REQ-005 byte_i  in  8  incoming frame byte from the UART receiver.
REQ-006 byte_valid_i  in  1  byte_i is valid this cycle.
REQ-007 byte_ready_o  out  1  loader can accept a byte this cycle.
REQ-008 done_i  in  1  one-cycle pulse from the encryption side: frame consumed, buffer may be released.
REQ-009 data_o  out  FRAME_BYTES*8  assembled frame; first received byte in bits [1471:1464].
REQ-010 start_o  out  1  one-cycle pulse requesting encryption of data_o.
REQ-011 frame_ready_o  out  1  data_o holds a complete, stable frame.
REQ-012 byte_count_o  out  8  bytes accepted in the current frame, 0..FRAME_BYTES-1.
REQ-013 error_o  out  1  one-cycle pulse: partial frame discarded on timeout.

Function
REQ-014 A byte SHALL be accepted only on a cycle with byte_valid_i=1 and byte_ready_o=1.
REQ-015 On acceptance, data_o SHALL shift left 8 bits, with byte_i inserted at [7:0]; after FRAME_BYTES accepts, the first byte SHALL sit at [1471:1464].
REQ-016 State IDLE: byte_ready_o=1, byte_count_o=0; an accepted byte SHALL move to LOAD with count 1.
REQ-017 State LOAD: byte_ready_o=1; each accept SHALL increment count by 1; an accept at count FRAME_BYTES-1 SHALL clear count to 0 and move to START.
REQ-018 State START: start_o=1 for exactly one cycle, byte_ready_o=0, frame_ready_o=1; next state SHALL be HOLD unconditionally.
REQ-019 State HOLD: byte_ready_o=0, frame_ready_o=1, data_o SHALL be held constant; done_i=1 SHALL move to IDLE.
REQ-020 Latency: start_o SHALL assert on the cycle immediately after the last byte is accepted.
REQ-021 done_i SHALL be ignored in IDLE, LOAD and START.
REQ-022 Outside START, start_o SHALL be 0; outside START/HOLD, frame_ready_o SHALL be 0.
REQ-023 data_o SHALL keep its last contents after leaving HOLD, until the next accepted byte.
REQ-024 byte_valid_i may drop for any number of cycles mid-frame without data corruption, subject to REQ-026.

Reset
REQ-025 reset_i=1 SHALL immediately force IDLE, data_o=0, byte_count_o=0, start_o=0, frame_ready_o=0, error_o=0, byte_ready_o=1 (IDLE value), and clear the gap timer; a partial or held frame SHALL be lost.

Configuration
REQ-026 With FRAME_TIMEOUT_EN defined: in LOAD, a gap counter SHALL clear on each accepted byte and increment otherwise; on reaching TIMEOUT_CYCLES it SHALL pulse error_o for one cycle, clear byte_count_o, and move to IDLE; data_o is left as-is.
REQ-027 Without FRAME_TIMEOUT_EN: no gap counter is implemented, error_o SHALL be tied 0, and LOAD waits indefinitely.

Structure
REQ-028 Shared package ecg_pkg SHALL hold FRAME_BYTES, FRAME_BITS (1472), BLOCK_BITS (64), and the loader state enum (IDLE, LOAD, START, HOLD).
REQ-029 The gap counter SHALL be the sub-module ecg_gap_timer (inputs clear/enable; output expired), instantiated only under FRAME_TIMEOUT_EN.

Verification
REQ-030 184 bytes 0x00..0xB7 back-to-back -> start_o high one cycle after last accept; data_o[1471:1464]=0x00, data_o[7:0]=0xB7; frame_ready_o=1.
REQ-031 Same bytes with random byte_valid_i gaps shorter than the timeout -> data_o identical to REQ-030; exactly one start_o pulse.
REQ-032 In HOLD, byte 0x5A offered -> byte_ready_o=0, data_o unchanged; done_i pulse -> IDLE; 0x5A accepted next cycle, byte_count_o=1.
REQ-033 done_i pulsed during LOAD at count 40 -> ignored; count continues to 41 on next accept.
REQ-034 reset_i asserted after 100 bytes -> data_o=0, byte_count_o=0, no start_o; a following 184-byte frame loads correctly.
REQ-035 FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=16: 50 bytes then 16 idle cycles -> single error_o pulse, byte_count_o=0; next 184 bytes give a correct frame. Without the macro -> error_o stays 0 and count stays 50.
